data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_pkg.sv | 19 +
 rtl/data_mem_lane.sv | 21 ++
 rtl/data_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data memory controller: access sizes and FSM states.
package data_mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/data_mem_lane.sv
// One byte lane of the data memory: 8-bit x 2**DEPTH_W, combinational read,
// write on the rising edge when we_n is low. Contents are never reset.
module data_mem_lane #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               we_n,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem_q [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (!we_n) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding byte-addressable data memory controller; response appears
// LAT+1 cycles after acceptance and is held until resp_ready.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int DEPTH_W = 8,
  parameter  int LAT     = 1,
  localparam int LANES   = DATA_W / 8,
  localparam int LB      = $clog2(LANES),
  localparam int AW      = DEPTH_W + LB
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [LB-1:0]      off;
  logic [DEPTH_W-1:0] widx;
  logic [3:0]         nbytes;
  logic [LB-1:0]      amask;
  logic               req_err;
  logic               accept;
  logic [LANES-1:0]   be;
  logic [LANES-1:0]   we_n;
  logic [DATA_W-1:0]  wshift;
  logic [DATA_W-1:0]  word_rd;
  logic [DATA_W-1:0]  sh;
  logic               sign_bit;
  logic [DATA_W-1:0]  ext;
  logic [DATA_W-1:0]  rdata_d;

  assign off     = req_addr[LB-1:0];
  assign widx    = req_addr[AW-1:LB];
  assign nbytes  = size_bytes(req_size);
  assign amask   = LB'(nbytes - 4'd1);
  assign req_err = ((off & amask) != '0) || ((req_size == SZ_DWORD) && (DATA_W == 32));
  assign accept  = (state_q == ST_IDLE) && req_valid;

  always_comb begin
    be = '0;
    for (int i = 0; i < LANES; i++) begin
      be[i] = (i >= int'(off)) && (i < int'(off) + int'(nbytes));
    end
  end

  // Erroneous requests must not touch memory, so the error gates every lane.
  assign we_n   = ~({LANES{accept && req_wr && !req_err}} & be);
  assign wshift = req_wdata << {off, 3'b000};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    data_mem_lane #(.DEPTH_W(DEPTH_W)) u_lane (
      .clk   (clk),
      .we_n  (we_n[gi]),
      .addr  (widx),
      .wdata (wshift[gi*8 +: 8]),
      .rdata (word_rd[gi*8 +: 8])
    );
  end

  assign sh = word_rd >> {off, 3'b000};

  always_comb begin
    case (req_size)
      SZ_BYTE: sign_bit = sh[7];
      SZ_HALF: sign_bit = sh[15];
      SZ_WORD: sign_bit = sh[31];
      default: sign_bit = sh[DATA_W-1];
    endcase
  end

  // Bits above the access width take the sign or zero; full-width loads keep every bit of sh.
  always_comb begin
    ext = '0;
    for (int b = 0; b < DATA_W; b++) begin
      ext[b] = (b < 8 * int'(nbytes)) ? sh[b] : (req_signed & sign_bit);
    end
  end

  assign rdata_d = (req_err || req_wr) ? '0 : ext;

  always_ff @(posedge clk) begin
    if (!rstd) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            rdata_q     <= rdata_d;
            err_q       <= req_err;
            req_ready_q <= 1'b0;
            if (LAT > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= 3'(LAT - 1);
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: instance 0 runs with LAT=1, instance 1 with LAT=3.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk;
  logic        rstd        [2];
  logic        req_valid   [2];
  logic        resp_ready  [2];
  logic        req_ready_w [2];
  logic        resp_valid_w[2];
  logic [31:0] resp_rdata_w[2];
  logic        resp_err_w  [2];

  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;

  int          n_checks;
  int          n_fail;
  logic [31:0] rd;
  logic        er;
  int          lat;

  data_mem_ctrl #(.DATA_W(32), .DEPTH_W(8), .LAT(1)) u_dut0 (
    .clk        (clk),
    .rstd       (rstd[0]),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready_w[0]),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid_w[0]),
    .resp_ready (resp_ready[0]),
    .resp_rdata (resp_rdata_w[0]),
    .resp_err   (resp_err_w[0])
  );

  data_mem_ctrl #(.DATA_W(32), .DEPTH_W(8), .LAT(3)) u_dut1 (
    .clk        (clk),
    .rstd       (rstd[1]),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready_w[1]),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid_w[1]),
    .resp_ready (resp_ready[1]),
    .resp_rdata (resp_rdata_w[1]),
    .resp_err   (resp_err_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // lat counts negedges from the acceptance edge to the first one showing resp_valid.
  task automatic do_req(input int d, input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [9:0] addr, input logic [31:0] wd, input int hold,
                        output logic [31:0] rdo, output logic ero, output int lato);
    @(negedge clk);
    req_wr     = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid[d] = 1'b1;
    chk("req_ready_idle", 64'(req_ready_w[d]), 64'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lato = 0;
    do begin
      @(negedge clk);
      lato++;
      if (!resp_valid_w[d]) chk("req_ready_busy", 64'(req_ready_w[d]), 64'd0);
    end while (!resp_valid_w[d] && lato < 20);
    chk("resp_valid_seen", 64'(resp_valid_w[d]), 64'd1);
    rdo = resp_rdata_w[d];
    ero = resp_err_w[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid_w[d]), 64'd1);
      chk("hold_rdata", 64'(resp_rdata_w[d]), 64'(rdo));
      chk("hold_err", 64'(resp_err_w[d]), 64'(ero));
      chk("hold_req_ready", 64'(req_ready_w[d]), 64'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1 resp_ready[d] = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready_w[d]), 64'd1);
    chk("idle_resp_valid", 64'(resp_valid_w[d]), 64'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rstd       = '{1'b0, 1'b0};
    req_valid  = '{1'b0, 1'b0};
    resp_ready = '{1'b0, 1'b0};
    req_wr     = 1'b0;
    req_size   = SZ_BYTE;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 64'(req_ready_w[d]), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid_w[d]), 64'd0);
      chk("rst_rdata", 64'(resp_rdata_w[d]), 64'd0);
      chk("rst_err", 64'(resp_err_w[d]), 64'd0);
    end
    rstd = '{1'b1, 1'b1};

    // Instance 0, LAT=1
    do_req(0, 1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEADBEEF, 0, rd, er, lat);
    chk("sw_err", 64'(er), 64'd0);
    chk("sw_rdata", 64'(rd), 64'd0);
    chk("sw_lat", 64'(lat), 64'd2);
    do_req(0, 1'b0, SZ_WORD, 1'b1, 10'h010, 32'h0, 0, rd, er, lat);
    chk("lw_rdata", 64'(rd), 64'hDEADBEEF);
    chk("lw_err", 64'(er), 64'd0);
    chk("lw_lat", 64'(lat), 64'd2);
    do_req(0, 1'b0, SZ_BYTE, 1'b1, 10'h013, 32'h0, 0, rd, er, lat);
    chk("lb_signed", 64'(rd), 64'hFFFFFFDE);
    do_req(0, 1'b0, SZ_BYTE, 1'b0, 10'h013, 32'h0, 0, rd, er, lat);
    chk("lbu", 64'(rd), 64'h000000DE);
    do_req(0, 1'b0, SZ_HALF, 1'b1, 10'h012, 32'h0, 0, rd, er, lat);
    chk("lh_signed", 64'(rd), 64'hFFFFDEAD);
    do_req(0, 1'b0, SZ_HALF, 1'b0, 10'h010, 32'h0, 0, rd, er, lat);
    chk("lhu", 64'(rd), 64'h0000BEEF);

    do_req(0, 1'b1, SZ_HALF, 1'b0, 10'h012, 32'hFFFF1234, 0, rd, er, lat);
    chk("sh_err", 64'(er), 64'd0);
    do_req(0, 1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 0, rd, er, lat);
    chk("sh_then_lw", 64'(rd), 64'h1234BEEF);

    do_req(0, 1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEADBEEF, 0, rd, er, lat);
    do_req(0, 1'b1, SZ_HALF, 1'b0, 10'h011, 32'h0000AAAA, 0, rd, er, lat);
    chk("mis_sh_err", 64'(er), 64'd1);
    chk("mis_sh_rdata", 64'(rd), 64'd0);
    do_req(0, 1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 0, rd, er, lat);
    chk("mis_sh_unchanged", 64'(rd), 64'hDEADBEEF);

    do_req(0, 1'b1, SZ_BYTE, 1'b0, 10'h011, 32'hFFFFFF55, 0, rd, er, lat);
    do_req(0, 1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 0, rd, er, lat);
    chk("sb_then_lw", 64'(rd), 64'hDEAD55EF);

    do_req(0, 1'b0, SZ_DWORD, 1'b0, 10'h010, 32'h0, 0, rd, er, lat);
    chk("dword_err", 64'(er), 64'd1);
    chk("dword_rdata", 64'(rd), 64'd0);
    do_req(0, 1'b0, SZ_WORD, 1'b0, 10'h012, 32'h0, 0, rd, er, lat);
    chk("mis_lw_err", 64'(er), 64'd1);
    chk("mis_lw_rdata", 64'(rd), 64'd0);

    do_req(0, 1'b1, SZ_WORD, 1'b0, 10'h3FC, 32'hA5A55A5A, 0, rd, er, lat);
    do_req(0, 1'b0, SZ_WORD, 1'b0, 10'h3FC, 32'h0, 0, rd, er, lat);
    chk("top_word", 64'(rd), 64'hA5A55A5A);

    // Instance 1, LAT=3, with response backpressure
    do_req(1, 1'b1, SZ_WORD, 1'b0, 10'h030, 32'h0BADF00D, 0, rd, er, lat);
    chk("l3_sw_lat", 64'(lat), 64'd4);
    do_req(1, 1'b0, SZ_WORD, 1'b0, 10'h030, 32'h0, 5, rd, er, lat);
    chk("l3_lw_lat", 64'(lat), 64'd4);
    chk("l3_lw_rdata", 64'(rd), 64'h0BADF00D);
    chk("l3_lw_err", 64'(er), 64'd0);

    // Reset one edge into WAIT of a store
    @(negedge clk);
    req_wr       = 1'b1;
    req_size     = SZ_WORD;
    req_signed   = 1'b0;
    req_addr     = 10'h020;
    req_wdata    = 32'hCAFEF00D;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("wait_no_valid", 64'(resp_valid_w[1]), 64'd0);
    rstd[1] = 1'b0;
    @(posedge clk);
    #1 rstd[1] = 1'b1;
    @(negedge clk);
    chk("rstw_req_ready", 64'(req_ready_w[1]), 64'd1);
    chk("rstw_resp_valid", 64'(resp_valid_w[1]), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rstw_no_resp", 64'(resp_valid_w[1]), 64'd0);
    end
    do_req(1, 1'b0, SZ_WORD, 1'b0, 10'h020, 32'h0, 0, rd, er, lat);
    chk("rstw_store_kept", 64'(rd), 64'hCAFEF00D);
    chk("rstw_load_err", 64'(er), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
